// File: rtl/video8bit_in_pack.sv
// 8-bit video capture front end: packs 8 pixels per 64-bit word (first pixel in [63:56]),
// pads short lines to whole words and feeds the DDR write FIFO. Optional macro: VIN_DROP_CNT_EN.
module video8bit_in_pack #(
    parameter int ADDR_BITS = 25
) (
    input  logic                 pclk,
    input  logic                 prst_n,
    input  logic                 invsync,
    input  logic                 inhsync,
    input  logic                 inde,
    input  logic [7:0]           indata,
    input  logic [23:0]          video_width,
    input  logic [11:0]          video_height,
    input  logic [ADDR_BITS-1:0] video_baseaddr,
    input  logic                 sync_fifo_full,
    output logic                 wr_req,
    output logic [63:0]          wr_data,
    output logic                 wr_data_en,
    output logic [ADDR_BITS-1:0] baseaddr,
    output logic [23:0]          ddr_line_length,
    output logic [11:0]          ddr_col_length,
    output logic                 req_end,
    output logic                 overflow,
    output logic [15:0]          drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FRAME, S_BLK, S_LINE, S_FLUSH, S_PAD, S_LEND, S_FEND
    } state_t;

    state_t                 state_q, state_d;
    logic                   vsync_q, vsync_d;
    logic [23:0]            width_q, width_d;
    logic [11:0]            height_q, height_d;
    logic [ADDR_BITS-1:0]   base_q, base_d;
    logic [23:0]            line_len_q, line_len_d;
    logic [2:0]             pix_idx_q, pix_idx_d;
    logic [23:0]            pix_cnt_q, pix_cnt_d;
    logic [63:0]            word_q, word_d;
    logic [23:0]            word_cnt_q, word_cnt_d;
    logic [11:0]            line_cnt_q, line_cnt_d;
    logic                   wr_req_q, wr_req_d;
    logic [63:0]            wr_data_q, wr_data_d;
    logic                   wr_data_en_q, wr_data_en_d;
    logic                   req_end_q, req_end_d;
    logic                   overflow_q, overflow_d;

    logic                   vs_rise, vs_fall;
    logic                   accept, push, drop, set_ovf;
    logic [63:0]            push_word;
    logic [63:0]            lane_word;
    logic [23:0]            flush_cnt;

    // hsync carries no control meaning here; the port exists only for interface symmetry.
    logic                   unused_inhsync;
    assign unused_inhsync = inhsync;

    assign vs_rise = invsync & ~vsync_q;
    assign vs_fall = ~invsync & vsync_q;

    // Current word with the incoming pixel merged into lane (7 - pix_idx).
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        localparam logic [2:0] LANE_IDX = 3'(7 - gi);
        assign lane_word[gi*8 +: 8] = (pix_idx_q == LANE_IDX) ? indata : word_q[gi*8 +: 8];
    end

    always_comb begin
        state_d      = state_q;
        vsync_d      = invsync;
        width_d      = width_q;
        height_d     = height_q;
        base_d       = base_q;
        line_len_d   = {3'b000, width_q[23:3]} + {23'd0, |width_q[2:0]};
        pix_idx_d    = pix_idx_q;
        pix_cnt_d    = pix_cnt_q;
        word_d       = word_q;
        word_cnt_d   = word_cnt_q;
        line_cnt_d   = line_cnt_q;
        wr_req_d     = 1'b0;
        wr_data_d    = wr_data_q;
        wr_data_en_d = 1'b0;
        req_end_d    = 1'b0;
        accept       = 1'b0;
        push         = 1'b0;
        drop         = 1'b0;
        set_ovf      = 1'b0;
        push_word    = word_q;
        flush_cnt    = word_cnt_q;

        if (invsync) begin
            width_d  = video_width;
            height_d = video_height;
            base_d   = video_baseaddr;
        end

        case (state_q)
            S_IDLE: begin
                if (vs_fall) begin
                    state_d  = S_FRAME;
                    wr_req_d = 1'b1;
                end
            end
            S_FRAME: begin
                line_cnt_d = 12'd0;
                word_cnt_d = 24'd0;
                pix_idx_d  = 3'd0;
                pix_cnt_d  = 24'd0;
                word_d     = 64'd0;
                state_d    = S_BLK;
            end
            S_BLK: begin
                if (inde) begin
                    accept  = (pix_cnt_q < width_q);
                    state_d = S_LINE;
                end
            end
            S_LINE: begin
                if (inde) begin
                    accept = (pix_cnt_q < width_q);
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                pix_idx_d = 3'd0;
                pix_cnt_d = 24'd0;
                word_d    = 64'd0;
                if (pix_idx_q != 3'd0) begin
                    push      = 1'b1;
                    push_word = word_q;
                    flush_cnt = word_cnt_q + 24'd1;
                end
                state_d = (flush_cnt < line_len_q) ? S_PAD : S_LEND;
            end
            S_PAD: begin
                // A new line starting here means the previous one is left short.
                if (inde) begin
                    set_ovf = 1'b1;
                    state_d = S_LEND;
                end else begin
                    push      = 1'b1;
                    push_word = 64'd0;
                    if (word_cnt_q + 24'd1 >= line_len_q) begin
                        state_d = S_LEND;
                    end
                end
            end
            S_LEND: begin
                line_cnt_d = line_cnt_q + 12'd1;
                word_cnt_d = 24'd0;
                if (line_cnt_d == height_q) begin
                    state_d   = S_FEND;
                    req_end_d = 1'b1;
                end else if (inde) begin
                    accept  = (pix_cnt_q < width_q);
                    state_d = S_LINE;
                end else begin
                    state_d = S_BLK;
                end
            end
            S_FEND: begin
                state_d = S_FEND;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            pix_cnt_d = pix_cnt_q + 24'd1;
            if (pix_idx_q == 3'd7) begin
                push      = 1'b1;
                push_word = lane_word;
                word_d    = 64'd0;
                pix_idx_d = 3'd0;
            end else begin
                word_d    = lane_word;
                pix_idx_d = pix_idx_q + 3'd1;
            end
        end

        // A dropped word still advances word_cnt so line addressing stays aligned.
        if (push) begin
            word_cnt_d = word_cnt_q + 24'd1;
            wr_data_d  = push_word;
            if (sync_fifo_full) begin
                drop = 1'b1;
            end else begin
                wr_data_en_d = 1'b1;
            end
        end

        if (vs_rise) begin
            state_d      = S_IDLE;
            pix_idx_d    = 3'd0;
            pix_cnt_d    = 24'd0;
            word_d       = 64'd0;
            wr_data_d    = wr_data_q;
            wr_data_en_d = 1'b0;
            req_end_d    = 1'b0;
            drop         = 1'b0;
        end

        overflow_d = invsync ? 1'b0 : (overflow_q | set_ovf | drop);
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b0;
            width_q      <= 24'd0;
            height_q     <= 12'd0;
            base_q       <= '0;
            line_len_q   <= 24'd0;
            pix_idx_q    <= 3'd0;
            pix_cnt_q    <= 24'd0;
            word_q       <= 64'd0;
            word_cnt_q   <= 24'd0;
            line_cnt_q   <= 12'd0;
            wr_req_q     <= 1'b0;
            wr_data_q    <= 64'd0;
            wr_data_en_q <= 1'b0;
            req_end_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            width_q      <= width_d;
            height_q     <= height_d;
            base_q       <= base_d;
            line_len_q   <= line_len_d;
            pix_idx_q    <= pix_idx_d;
            pix_cnt_q    <= pix_cnt_d;
            word_q       <= word_d;
            word_cnt_q   <= word_cnt_d;
            line_cnt_q   <= line_cnt_d;
            wr_req_q     <= wr_req_d;
            wr_data_q    <= wr_data_d;
            wr_data_en_q <= wr_data_en_d;
            req_end_q    <= req_end_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef VIN_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (vs_fall) begin
            drop_cnt_d = 16'h0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'h1;
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            drop_cnt_q <= 16'h0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'h0;
`endif

    assign wr_req          = wr_req_q;
    assign wr_data         = wr_data_q;
    assign wr_data_en      = wr_data_en_q;
    assign baseaddr        = base_q;
    assign ddr_line_length = line_len_q;
    assign ddr_col_length  = height_q;
    assign req_end         = req_end_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_video8bit_in_pack.sv
// Directed bench for video8bit_in_pack: packing, partial/pad words, FIFO-full drops,
// vsync abort and mid-line reset, with expected words computed by hand.
module tb_video8bit_in_pack;

    logic        pclk;
    logic        prst_n;
    logic        invsync;
    logic        inhsync;
    logic        inde;
    logic [7:0]  indata;
    logic [23:0] video_width;
    logic [11:0] video_height;
    logic [24:0] video_baseaddr;
    logic        sync_fifo_full;
    logic        wr_req;
    logic [63:0] wr_data;
    logic        wr_data_en;
    logic [24:0] baseaddr;
    logic [23:0] ddr_line_length;
    logic [11:0] ddr_col_length;
    logic        req_end;
    logic        overflow;
    logic [15:0] drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    int          push_n, wr_req_n, req_end_n, req_end_at;
    logic [63:0] push_data [0:15];

    video8bit_in_pack #(.ADDR_BITS(25)) dut (
        .pclk           (pclk),
        .prst_n         (prst_n),
        .invsync        (invsync),
        .inhsync        (inhsync),
        .inde           (inde),
        .indata         (indata),
        .video_width    (video_width),
        .video_height   (video_height),
        .video_baseaddr (video_baseaddr),
        .sync_fifo_full (sync_fifo_full),
        .wr_req         (wr_req),
        .wr_data        (wr_data),
        .wr_data_en     (wr_data_en),
        .baseaddr       (baseaddr),
        .ddr_line_length(ddr_line_length),
        .ddr_col_length (ddr_col_length),
        .req_end        (req_end),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Output monitor, sampled on the falling edge; one line per pushed word.
    always @(negedge pclk) begin
        if (wr_data_en) begin
            if (push_n < 16) push_data[push_n] = wr_data;
            $display("push %0d: wr_data=%h", push_n, wr_data);
            push_n++;
        end
        if (wr_req) wr_req_n++;
        if (req_end) begin
            req_end_n++;
            req_end_at = push_n;
        end
    end

    task automatic clr_mon();
        @(posedge pclk);
        #1;
        push_n = 0; wr_req_n = 0; req_end_n = 0; req_end_at = -1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge pclk);
    endtask

    task automatic start_frame(input logic [23:0] w, input logic [11:0] h, input logic [24:0] b);
        @(negedge pclk);
        invsync = 1'b1; video_width = w; video_height = h; video_baseaddr = b;
        idle(3);
        clr_mon();
        @(negedge pclk);
        invsync = 1'b0;
        idle(2);
    endtask

    task automatic send_line(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            inde = 1'b1; indata = first + 8'(i);
        end
        @(negedge pclk);
        inde = 1'b0; indata = 8'h00;
    endtask

    task automatic test_reset();
        idle(2);
        n_cmp++; if (wr_data !== 64'd0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        n_cmp++; if ({wr_req, wr_data_en, req_end, overflow} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {wr_req, wr_data_en, req_end, overflow}); end
        n_cmp++; if (baseaddr !== 25'd0 || ddr_line_length !== 24'd0 || ddr_col_length !== 12'd0) begin n_fail++; $display("FAIL reset_cfg: got %h/%h/%h expected 0/0/0", baseaddr, ddr_line_length, ddr_col_length); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %h expected 0", drop_cnt); end
        @(negedge pclk);
        prst_n = 1'b1;
        idle(2);
        $display("test_reset done");
    endtask

    task automatic test_pack_w16();
        start_frame(24'd16, 12'd2, 25'h0123456);
        send_line(16, 8'h00);
        idle(4);
        send_line(16, 8'h00);
        idle(6);
        n_cmp++; if (push_n !== 4) begin n_fail++; $display("FAIL w16_push_count: got %0d expected 4", push_n); end
        n_cmp++; if (push_data[0] !== 64'h0001020304050607) begin n_fail++; $display("FAIL w16_word0: got %h expected 0001020304050607", push_data[0]); end
        n_cmp++; if (push_data[1] !== 64'h08090A0B0C0D0E0F) begin n_fail++; $display("FAIL w16_word1: got %h expected 08090a0b0c0d0e0f", push_data[1]); end
        n_cmp++; if (push_data[2] !== 64'h0001020304050607) begin n_fail++; $display("FAIL w16_word2: got %h expected 0001020304050607", push_data[2]); end
        n_cmp++; if (push_data[3] !== 64'h08090A0B0C0D0E0F) begin n_fail++; $display("FAIL w16_word3: got %h expected 08090a0b0c0d0e0f", push_data[3]); end
        n_cmp++; if (wr_req_n !== 1) begin n_fail++; $display("FAIL w16_wr_req_count: got %0d expected 1", wr_req_n); end
        n_cmp++; if (req_end_n !== 1 || req_end_at !== 4) begin n_fail++; $display("FAIL w16_req_end: got %0d pulses after %0d pushes expected 1 after 4", req_end_n, req_end_at); end
        n_cmp++; if (ddr_line_length !== 24'd2 || ddr_col_length !== 12'd2) begin n_fail++; $display("FAIL w16_lengths: got %0d/%0d expected 2/2", ddr_line_length, ddr_col_length); end
        n_cmp++; if (baseaddr !== 25'h0123456) begin n_fail++; $display("FAIL w16_baseaddr: got %h expected 0123456", baseaddr); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL w16_overflow: got %b expected 0", overflow); end
        // Pixels arriving after the frame has ended must be ignored.
        send_line(8, 8'h40);
        idle(4);
        n_cmp++; if (push_n !== 4) begin n_fail++; $display("FAIL fend_ignore: got %0d pushes expected 4", push_n); end
        $display("test_pack_w16 done");
    endtask

    task automatic test_partial_w13();
        start_frame(24'd13, 12'd1, 25'h0000100);
        send_line(16, 8'h00);
        idle(6);
        n_cmp++; if (ddr_line_length !== 24'd2) begin n_fail++; $display("FAIL w13_line_length: got %0d expected 2", ddr_line_length); end
        n_cmp++; if (push_n !== 2) begin n_fail++; $display("FAIL w13_push_count: got %0d expected 2", push_n); end
        n_cmp++; if (push_data[0] !== 64'h0001020304050607) begin n_fail++; $display("FAIL w13_word0: got %h expected 0001020304050607", push_data[0]); end
        n_cmp++; if (push_data[1] !== 64'h08090A0B0C000000) begin n_fail++; $display("FAIL w13_word1: got %h expected 08090a0b0c000000", push_data[1]); end
        n_cmp++; if (req_end_n !== 1) begin n_fail++; $display("FAIL w13_req_end: got %0d expected 1", req_end_n); end
        $display("test_partial_w13 done");
    endtask

    task automatic test_pad_w24();
        start_frame(24'd24, 12'd1, 25'h0000200);
        send_line(10, 8'h00);
        idle(8);
        n_cmp++; if (ddr_line_length !== 24'd3) begin n_fail++; $display("FAIL w24_line_length: got %0d expected 3", ddr_line_length); end
        n_cmp++; if (push_n !== 3) begin n_fail++; $display("FAIL w24_push_count: got %0d expected 3", push_n); end
        n_cmp++; if (push_data[1] !== 64'h0809000000000000) begin n_fail++; $display("FAIL w24_partial: got %h expected 0809000000000000", push_data[1]); end
        n_cmp++; if (push_data[2] !== 64'h0) begin n_fail++; $display("FAIL w24_pad: got %h expected 0", push_data[2]); end
        n_cmp++; if (req_end_n !== 1 || req_end_at !== 3) begin n_fail++; $display("FAIL w24_req_end: got %0d after %0d expected 1 after 3", req_end_n, req_end_at); end
        $display("test_pad_w24 done");
    endtask

    task automatic test_fifo_full();
        logic [15:0] exp_drop;
`ifdef VIN_DROP_CNT_EN
        exp_drop = 16'd1;
`else
        exp_drop = 16'd0;
`endif
        start_frame(24'd16, 12'd1, 25'h0000300);
        for (int i = 0; i < 16; i++) begin
            @(negedge pclk);
            inde = 1'b1; indata = 8'(i);
            sync_fifo_full = (i >= 8);
        end
        @(negedge pclk);
        inde = 1'b0; indata = 8'h00; sync_fifo_full = 1'b0;
        idle(6);
        n_cmp++; if (push_n !== 1 || push_data[0] !== 64'h0001020304050607) begin n_fail++; $display("FAIL full_push: got %0d pushes first %h expected 1 of 0001020304050607", push_n, push_data[0]); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow: got %b expected 1", overflow); end
        n_cmp++; if (drop_cnt !== exp_drop) begin n_fail++; $display("FAIL full_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop); end
        n_cmp++; if (req_end_n !== 1) begin n_fail++; $display("FAIL full_req_end: got %0d expected 1", req_end_n); end
        @(negedge pclk);
        invsync = 1'b1;
        idle(2);
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_overflow_clear: got %b expected 0", overflow); end
        $display("test_fifo_full done");
    endtask

    task automatic test_vsync_abort();
        start_frame(24'd16, 12'd4, 25'h0000400);
        send_line(16, 8'h00);
        idle(4);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            inde = 1'b1; indata = 8'h80 + 8'(i);
        end
        @(negedge pclk);
        inde = 1'b0; indata = 8'h00; invsync = 1'b1;
        idle(6);
        send_line(8, 8'h90);
        idle(4);
        n_cmp++; if (push_n !== 2) begin n_fail++; $display("FAIL abort_push_count: got %0d expected 2", push_n); end
        n_cmp++; if (req_end_n !== 0) begin n_fail++; $display("FAIL abort_req_end: got %0d expected 0", req_end_n); end
        start_frame(24'd16, 12'd4, 25'h1ABCDEF);
        n_cmp++; if (baseaddr !== 25'h1ABCDEF) begin n_fail++; $display("FAIL abort_new_base: got %h expected 1abcdef", baseaddr); end
        n_cmp++; if (wr_req_n !== 1) begin n_fail++; $display("FAIL abort_new_wr_req: got %0d expected 1", wr_req_n); end
        $display("test_vsync_abort done");
    endtask

    task automatic test_reset_midline();
        start_frame(24'd16, 12'd1, 25'h0000500);
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            inde = 1'b1; indata = 8'hA0 + 8'(i);
        end
        prst_n = 1'b0;
        @(negedge pclk);
        n_cmp++; if (wr_data !== 64'd0 || wr_data_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_data: got %h/%b expected 0/0", wr_data, wr_data_en); end
        n_cmp++; if (baseaddr !== 25'd0 || ddr_line_length !== 24'd0 || ddr_col_length !== 12'd0) begin n_fail++; $display("FAIL rst_mid_cfg: got %h/%h/%h expected 0/0/0", baseaddr, ddr_line_length, ddr_col_length); end
        n_cmp++; if ({wr_req, req_end, overflow} !== 3'b0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_mid_flags: got %b/%h expected 000/0", {wr_req, req_end, overflow}, drop_cnt); end
        inde = 1'b0; indata = 8'h00;
        @(negedge pclk);
        prst_n = 1'b1;
        idle(2);
        start_frame(24'd16, 12'd1, 25'h0000600);
        send_line(16, 8'h10);
        idle(6);
        n_cmp++; if (push_n !== 2 || push_data[0] !== 64'h1011121314151617 || push_data[1] !== 64'h18191A1B1C1D1E1F) begin n_fail++; $display("FAIL rst_clean_frame: got %0d pushes %h %h expected 2 1011121314151617 18191a1b1c1d1e1f", push_n, push_data[0], push_data[1]); end
        n_cmp++; if (req_end_n !== 1 || baseaddr !== 25'h0000600) begin n_fail++; $display("FAIL rst_clean_end: got %0d req_end base %h expected 1 base 0000600", req_end_n, baseaddr); end
        $display("test_reset_midline done");
    endtask

    initial begin
        prst_n = 1'b0; invsync = 1'b0; inhsync = 1'b0; inde = 1'b0; indata = 8'h00;
        video_width = 24'd0; video_height = 12'd0; video_baseaddr = 25'd0; sync_fifo_full = 1'b0;
        push_n = 0; wr_req_n = 0; req_end_n = 0; req_end_at = -1;
        test_reset();
        test_pack_w16();
        test_partial_w13();
        test_pad_w24();
        test_fifo_full();
        test_vsync_abort();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
